// File: rtl/clk_reset_sequencer.sv
// Reset sequencer for the 200 MHz domain: qualifies MMCM lock, then releases
// system, AXI-Lite and AXI-Stream resets in order; any lock loss re-asserts all.
module clk_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGE_DELAY        = 16,
  parameter int CNT_W              = 8
) (
  input  logic             clk_200,
  input  logic             reset,
  input  logic             locked,
  output logic             sys_reset,
  output logic             axi_resetn,
  output logic             axis_resetn,
  output logic             ready,
  output logic [CNT_W-1:0] lock_loss_cnt,
  output logic [2:0]       seq_state
);

  localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES) + 1;
  localparam int STAGE_W  = $clog2(STAGE_DELAY) + 1;

  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [STAGE_W-1:0]  STAGE_LAST  = STAGE_W'(STAGE_DELAY - 1);
  localparam logic [CNT_W-1:0]    LOSS_MAX    = '1;

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    REL_SYS   = 3'd1,
    REL_AXI   = 3'd2,
    RUN       = 3'd3
  } state_t;

  typedef struct packed {
    logic sys_reset;
    logic axi_resetn;
    logic axis_resetn;
    logic ready;
  } rst_out_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lk_s;

  state_t              state_q, state_d;
  logic [STABLE_W-1:0] stable_q, stable_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [CNT_W-1:0]    loss_q, loss_d;
  rst_out_t            out_q, out_d;

  // `locked` comes from the MMCM with no relation to clk_200.
  // NOTE: every clocked process uses non-blocking assignments so all flops
  // update from pre-edge values; blocking here would collapse the chain.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
    end
  end

  assign lk_s = sync_q[SYNC_STAGES-1];

  // State register with its counters.
  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      state_q  <= WAIT_LOCK;
      stable_q <= '0;
      stage_q  <= '0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      stable_q <= stable_d;
      stage_q  <= stage_d;
      loss_q   <= loss_d;
    end
  end

  // Next-state logic. A lost lock outside WAIT_LOCK beats any pending advance.
  // NOTE: every signal assigned here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    stage_d  = stage_q;
    loss_d   = loss_q;
    case (state_q)
      WAIT_LOCK: begin
        if (!lk_s) begin
          stable_d = '0;
        end else if (stable_q == STABLE_LAST) begin
          state_d  = REL_SYS;
          stable_d = '0;
          stage_d  = '0;
        end else begin
          stable_d = stable_q + 1'b1;
        end
      end
      REL_SYS, REL_AXI: begin
        if (!lk_s) begin
          state_d  = WAIT_LOCK;
          stable_d = '0;
          stage_d  = '0;
          if (loss_q != LOSS_MAX) loss_d = loss_q + 1'b1;
        end else if (stage_q == STAGE_LAST) begin
          state_d = (state_q == REL_SYS) ? REL_AXI : RUN;
          stage_d = '0;
        end else begin
          stage_d = stage_q + 1'b1;
        end
      end
      RUN: begin
        if (!lk_s) begin
          state_d  = WAIT_LOCK;
          stable_d = '0;
          stage_d  = '0;
          if (loss_q != LOSS_MAX) loss_d = loss_q + 1'b1;
        end
      end
      default: begin
        // Unused encodings fall back to the safe, fully-reset state.
        state_d  = WAIT_LOCK;
        stable_d = '0;
        stage_d  = '0;
      end
    endcase
  end

  // Decode of the upcoming state, registered below so the resets leave flops
  // glitch-free while still matching the current state after each edge.
  always_comb begin
    out_d = '{sys_reset: 1'b1, axi_resetn: 1'b0, axis_resetn: 1'b0, ready: 1'b0};
    case (state_d)
      REL_SYS: out_d = '{sys_reset: 1'b0, axi_resetn: 1'b0, axis_resetn: 1'b0, ready: 1'b0};
      REL_AXI: out_d = '{sys_reset: 1'b0, axi_resetn: 1'b1, axis_resetn: 1'b0, ready: 1'b0};
      RUN:     out_d = '{sys_reset: 1'b0, axi_resetn: 1'b1, axis_resetn: 1'b1, ready: 1'b1};
      default: out_d = '{sys_reset: 1'b1, axi_resetn: 1'b0, axis_resetn: 1'b0, ready: 1'b0};
    endcase
  end

  always_ff @(posedge clk_200 or posedge reset) begin
    if (reset) begin
      out_q <= '{sys_reset: 1'b1, axi_resetn: 1'b0, axis_resetn: 1'b0, ready: 1'b0};
    end else begin
      out_q <= out_d;
    end
  end

  assign sys_reset     = out_q.sys_reset;
  assign axi_resetn    = out_q.axi_resetn;
  assign axis_resetn   = out_q.axis_resetn;
  assign ready         = out_q.ready;
  assign lock_loss_cnt = loss_q;
  assign seq_state     = state_q;

endmodule
